paraacc_16p16: RTL and testbench

PARAACC_16P16 -- requirements
Module: paraacc_16p16

---
 rtl/paraacc_16p16.sv | 125 ++++++++++++
 tb/tb_paraacc_16p16.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/paraacc_16p16.sv
`default_nettype none
// ============================================================================
// Module      : paraacc_16p16
// Description : Lane-parallel saturating accumulator. Sums a job of cfg_len
//               beats of packed signed lanes, then holds the result until
//               the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module paraacc_16p16 #(
  parameter int LANES = 16,
  parameter int LW    = 16,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       cfg_len,
  input  logic                cfg_load,
  input  logic [LANES*LW-1:0] in_data,
  input  logic                in_v,
  output logic [LANES*LW-1:0] out_data,
  output logic                out_v,
  input  logic                out_ready,
  output logic                busy,
  output logic                sat_flag,
  output logic                drop_err
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_acc  = 2'd1;
  localparam logic [1:0] c_hold = 2'd2;

  localparam logic [CW-1:0] c_cnt_zero = '0;
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [LANES*LW-1:0] r_acc;
  logic                r_first;
  logic                r_sat;
  logic                r_drop;

  logic [LANES*LW-1:0] w_sum_vec;
  logic [LANES-1:0]    w_sat_vec;
  logic                w_start;

  // A zero-length job would never produce a result, so it is not started.
  assign w_start = cfg_load && (cfg_len != c_cnt_zero);

  // Per-lane saturating add; lanes are fully independent (no carry between).
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LW:0]   w_sum;
    logic          w_ovf;
    logic [LW-1:0] w_lane;

    assign w_sum = {r_acc[gi*LW+LW-1], r_acc[gi*LW +: LW]}
                 + {in_data[gi*LW+LW-1], in_data[gi*LW +: LW]};
    // Overflow when the extra sign bit disagrees with the result sign bit.
    assign w_ovf  = w_sum[LW] ^ w_sum[LW-1];
    assign w_lane = !w_ovf      ? w_sum[LW-1:0] :
                    w_sum[LW]   ? {1'b1, {(LW-1){1'b0}}} :
                                  {1'b0, {(LW-1){1'b1}}};
    assign w_sum_vec[gi*LW +: LW] = w_lane;
    assign w_sat_vec[gi]          = w_ovf;
  end

  // Job FSM, beat counter, accumulator and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_idle;
      r_cnt   <= c_cnt_zero;
      r_acc   <= '0;
      r_first <= 1'b0;
      r_sat   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_v) r_drop <= 1'b1;
          if (w_start) begin
            r_state <= c_acc;
            r_cnt   <= cfg_len;
            r_first <= 1'b1;
            r_sat   <= 1'b0;
          end
        end
        c_acc: begin
          if (in_v) begin
            // First beat of a job replaces whatever the previous job left.
            if (r_first) begin
              r_acc <= in_data;
            end else begin
              r_acc <= w_sum_vec;
              if (|w_sat_vec) r_sat <= 1'b1;
            end
            r_first <= 1'b0;
            r_cnt   <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) r_state <= c_hold;
          end
        end
        c_hold: begin
          if (in_v) r_drop <= 1'b1;
          if (out_ready) begin
            if (w_start) begin
              r_state <= c_acc;
              r_cnt   <= cfg_len;
              r_first <= 1'b1;
              r_sat   <= 1'b0;
            end else begin
              r_state <= c_idle;
            end
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign out_data = r_acc;
  assign out_v    = (r_state == c_hold);
  assign busy     = (r_state == c_acc) || (r_state == c_hold);
  assign sat_flag = r_sat;
  assign drop_err = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_paraacc_16p16.sv
`default_nettype none
// ============================================================================
// Module      : tb_paraacc_16p16
// Description : Directed self-checking bench for paraacc_16p16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paraacc_16p16;

  localparam int LANES = 16;
  localparam int LW    = 16;
  localparam int CW    = 8;
  localparam int VW    = LANES * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_len;
  logic          cfg_load;
  logic [VW-1:0] in_data;
  logic          in_v;
  logic [VW-1:0] out_data;
  logic          out_v;
  logic          out_ready;
  logic          busy;
  logic          sat_flag;
  logic          drop_err;

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] held;
  logic [VW-1:0] v2;

  paraacc_16p16 #(.LANES(LANES), .LW(LW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .cfg_load  (cfg_load),
    .in_data   (in_data),
    .in_v      (in_v),
    .out_data  (out_data),
    .out_v     (out_v),
    .out_ready (out_ready),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] fill(input logic [LW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] obs,
                         input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; cfg_len = '0; cfg_load = 1'b0; in_data = '0;
    in_v = 1'b1; out_ready = 1'b0;
    // Reset with in_v active must not set drop_err.
    tick(); tick();
    in_v = 1'b0;
    chk_bit("rst_out_v", out_v, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_sat", sat_flag, 1'b0);
    chk_bit("rst_drop", drop_err, 1'b0);
    chk_vec("rst_data", out_data, '0);
    rst = 1'b1;
    tick();

    // Job: 1+2+3 on every lane.
    cfg_len = 8'd3; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk_bit("j1_busy", busy, 1'b1);
    in_v = 1'b1; in_data = fill(16'h0001); tick();
    in_data = fill(16'h0002); tick();
    in_data = fill(16'h0003);
    chk_bit("j1_no_early_v", out_v, 1'b0);
    tick();
    in_v = 1'b0;
    chk_bit("j1_out_v", out_v, 1'b1);
    chk_vec("j1_data", out_data, fill(16'h0006));
    chk_bit("j1_sat", sat_flag, 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_bit("j1_idle_v", out_v, 1'b0);
    chk_bit("j1_idle_busy", busy, 1'b0);

    // Saturation both directions on lanes 0 and 1.
    cfg_len = 8'd2; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    v2 = '0; v2[15:0] = 16'h7FF0; v2[31:16] = 16'h8001;
    in_v = 1'b1; in_data = v2; tick();
    v2 = '0; v2[15:0] = 16'h0020; v2[31:16] = 16'hFFF0;
    in_data = v2; tick();
    in_v = 1'b0;
    v2 = '0; v2[15:0] = 16'h7FFF; v2[31:16] = 16'h8000;
    chk_bit("j2_out_v", out_v, 1'b1);
    chk_vec("j2_data", out_data, v2);
    chk_bit("j2_sat", sat_flag, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Zero-length load is ignored and leaves sat_flag alone.
    cfg_len = 8'd0; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk_bit("zl_busy", busy, 1'b0);
    chk_bit("zl_sat_kept", sat_flag, 1'b1);
    tick();
    chk_bit("zl_busy2", busy, 1'b0);

    // Gapped beats and a stalled consumer.
    cfg_len = 8'd2; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk_bit("j3_sat_clr", sat_flag, 1'b0);
    in_v = 1'b1; in_data = fill(16'h0004); tick(); in_v = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_bit("j3_gap_busy", busy, 1'b1);
    chk_bit("j3_gap_v", out_v, 1'b0);
    in_v = 1'b1; in_data = fill(16'h0003); tick(); in_v = 1'b0;
    held = fill(16'h0007);
    for (int i = 0; i < 4; i++) begin
      chk_bit("j3_hold_v", out_v, 1'b1);
      chk_vec("j3_hold_data", out_data, held);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_bit("j3_idle_busy", busy, 1'b0);
    chk_bit("j3_idle_v", out_v, 1'b0);

    // Back-to-back jobs through HOLD.
    cfg_len = 8'd1; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    in_v = 1'b1; in_data = fill(16'h0002); tick(); in_v = 1'b0;
    chk_vec("j4a_data", out_data, fill(16'h0002));
    out_ready = 1'b1; cfg_load = 1'b1; cfg_len = 8'd1; tick();
    out_ready = 1'b0; cfg_load = 1'b0;
    chk_bit("j4_acc_busy", busy, 1'b1);
    chk_bit("j4_acc_v", out_v, 1'b0);
    in_v = 1'b1; in_data = fill(16'h0005); tick(); in_v = 1'b0;
    chk_bit("j4b_out_v", out_v, 1'b1);
    chk_vec("j4b_data", out_data, fill(16'h0005));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Stray beat in IDLE.
    chk_bit("drop_pre", drop_err, 1'b0);
    in_v = 1'b1; in_data = fill(16'h1234); tick(); in_v = 1'b0;
    chk_bit("drop_set", drop_err, 1'b1);
    chk_bit("drop_busy", busy, 1'b0);
    tick();
    chk_bit("drop_sticky", drop_err, 1'b1);

    // Reset mid-job abandons it.
    cfg_len = 8'd4; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    in_v = 1'b1; in_data = fill(16'h0100); tick(); tick();
    rst = 1'b0; tick();
    rst = 1'b1; in_v = 1'b0;
    chk_bit("mr_busy", busy, 1'b0);
    chk_bit("mr_drop", drop_err, 1'b0);
    chk_vec("mr_data", out_data, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("mr_no_v", out_v, 1'b0);
    end
    cfg_len = 8'd1; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    in_v = 1'b1; in_data = fill(16'h0009); tick(); in_v = 1'b0;
    chk_bit("mr_j_v", out_v, 1'b1);
    chk_vec("mr_j_data", out_data, fill(16'h0009));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
